// File: rtl/modular_exp_sqm.sv
// modular_exp_sqm: P = X^Y mod M by left-to-right binary square-and-multiply,
// sequencing one modular_multiplier through its mstart/mdone handshake.
// Optional build macro: MODEXP_CONST_TIME_EN (fixed square+multiply per bit,
// latency independent of Y).

// Bit-serial interleaved modular multiplier: product = a*b mod m after n
// cycles, mdone pulses once with the result. Requires a, b < m.
module modular_multiplier #(
  parameter int n = 1024
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         mstart,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] m,
  output logic [n-1:0] product,
  output logic         mdone
);
  localparam int CW = $clog2(n + 1);

  logic [n-1:0]  a_sh, br, mq;
  logic [n:0]    r_nxt;
  logic [CW-1:0] cnt;
  logic          run;

  // One MSB-first step: r = 2r mod m, then conditionally add b mod m.
  always_comb begin
    r_nxt = {product, 1'b0};
    if (r_nxt >= {1'b0, mq}) r_nxt = r_nxt - {1'b0, mq};
    if (a_sh[n-1]) r_nxt = r_nxt + {1'b0, br};
    if (r_nxt >= {1'b0, mq}) r_nxt = r_nxt - {1'b0, mq};
  end

  // Operand capture, iteration counter and done pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_sh    <= '0;
      br      <= '0;
      mq      <= '0;
      product <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      mdone   <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (mstart) begin
        a_sh    <= a;
        br      <= b;
        mq      <= m;
        product <= '0;
        cnt     <= CW'(n);
        run     <= 1'b1;
      end else if (run) begin
        product <= r_nxt[n-1:0];
        a_sh    <= a_sh << 1;
        cnt     <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run   <= 1'b0;
          mdone <= 1'b1;
        end
      end
    end
  end
endmodule

module modular_exp_sqm #(
  parameter int N = 1024,
  parameter int E = 1024
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [E-1:0] Y,
  input  logic [N-1:0] M,
  output logic [N-1:0] P,
  output logic         done,
  output logic         busy
);
  localparam int IW = (E > 1) ? $clog2(E) : 1;
`ifdef MODEXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, SCAN, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, NEXT, FINISH, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  xr, mr, acc, op_b, product;
  logic [E-1:0]  yr;
  logic [IW-1:0] i;
  logic          mstart, mdone, accept, bit_set, i_zero;

  assign accept  = start && (state == IDLE || state == DONE);
  assign bit_set = yr[i];
  assign i_zero  = (i == '0);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE) && (state != DONE);

  modular_multiplier #(.n(N)) u_mul (
    .clk     (clk),
    .n_reset (n_reset),
    .mstart  (mstart),
    .a       (acc),
    .b       (op_b),
    .m       (mr),
    .product (product),
    .mdone   (mdone)
  );

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state, multiplier start pulse and operand select.
  always_comb begin
    state_nxt = state;
    mstart    = 1'b0;
    op_b      = acc;
    case (state)
      IDLE, DONE: if (start) state_nxt = CONST_TIME ? SQ_START : SCAN;
      SCAN: begin
        if (bit_set)     state_nxt = SQ_START;
        else if (i_zero) state_nxt = FINISH;
      end
      SQ_START: begin
        mstart    = 1'b1;
        state_nxt = SQ_WAIT;
      end
      SQ_WAIT: if (mdone) state_nxt = (CONST_TIME || bit_set) ? MUL_START : NEXT;
      MUL_START: begin
        mstart    = 1'b1;
        op_b      = xr;
        state_nxt = MUL_WAIT;
      end
      MUL_WAIT: begin
        op_b = xr;
        if (mdone) state_nxt = NEXT;
      end
      NEXT:    state_nxt = i_zero ? FINISH : SQ_START;
      FINISH:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, accumulator, bit index and result register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      xr  <= '0;
      yr  <= '0;
      mr  <= '0;
      acc <= '0;
      i   <= '0;
      P   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          xr  <= X;
          yr  <= Y;
          mr  <= M;
          acc <= (M == N'(1)) ? '0 : N'(1);
          i   <= IW'(E - 1);
        end
        SCAN:     if (!bit_set && !i_zero) i <= i - 1'b1;
        SQ_WAIT:  if (mdone) acc <= product;
        // Constant-time mode always multiplies but keeps acc on a zero bit.
        MUL_WAIT: if (mdone && (!CONST_TIME || bit_set)) acc <= product;
        NEXT:     if (!i_zero) i <= i - 1'b1;
        FINISH:   P <= acc;
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_modular_exp_sqm.sv
// Scoreboard bench for modular_exp_sqm (N=16, E=8).
module tb_modular_exp_sqm;
  localparam int N = 16;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] X = '0, M = '0;
  logic [E-1:0] Y = '0;
  logic [N-1:0] P;
  logic         done, busy;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int cyc_cnt = 0;
  longint exp_q[$];

  modular_exp_sqm #(.N(N), .E(E)) dut (
    .clk(clk), .n_reset(n_reset), .start(start),
    .X(X), .Y(Y), .M(M), .P(P), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running counters; ops take differences.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (dut.mstart) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input longint x, input longint y, input longint m);
    longint r;
    r = 1 % m;
    for (longint k = 0; k < y; k++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int exp_pulses(input int y);
    int msb;
`ifdef MODEXP_CONST_TIME_EN
    return 2 * E;
`else
    if (y == 0) return 0;
    msb = 0;
    for (int b = 0; b < E; b++) if (y[b]) msb = b;
    return (msb + 1) + $countones(y);
`endif
  endfunction

  int p0, c0;

  task automatic start_op(input int x, input int y, input int m, input bit push);
    @(negedge clk);
    X = N'(x); Y = E'(y); M = N'(m); start = 1'b1;
    if (push) exp_q.push_back(model(x, y, m));
    p0 = pulse_cnt; c0 = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_dropped", done, 0);
  endtask

  task automatic finish_op(input string tag, input int y, output int cycles);
    int n;
    longint e;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    e = exp_q.pop_front();
    chk({tag, "_P"}, P, e);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pulses"}, pulse_cnt - p0, exp_pulses(y));
    cycles = cyc_cnt - c0;
  endtask

  task automatic run_op(input string tag, input int x, input int y, input int m,
                        output int cycles);
    start_op(x, y, m, 1'b1);
    finish_op(tag, y, cycles);
  endtask

  initial begin
    int cy_a, cy_b, n;
    #12;
    chk("rst_P", P, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    n_reset = 1'b1;

    run_op("x4y13", 4, 13, 497, cy_a);
    chk("x4y13_const", P, 445);
    run_op("x3y5", 3, 5, 1000, cy_a);
    chk("x3y5_const", P, 243);
    run_op("x3y1", 3, 1, 1000, cy_b);
`ifdef MODEXP_CONST_TIME_EN
    chk("const_time_cycles", cy_a, cy_b);
`endif
    run_op("y0", 5, 0, 7, cy_a);
    chk("y0_const", P, 1);
    run_op("m1", 0, 9, 1, cy_a);
    run_op("x200y255", 200, 255, 65521, cy_a);

    // Second start mid-run must be ignored.
    start_op(2, 10, 1000, 1'b1);
    repeat (30) @(negedge clk);
    X = 16'd3; Y = 8'd7; M = 16'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    X = '0; Y = '0; M = '0;
    finish_op("ignore_start", 10, cy_a);
    chk("ignore_start_const", P, 24);

    // Reset while a square is in flight: asynchronous abort.
    start_op(5, 200, 999, 1'b0);
    n = 0;
    while (!dut.mstart && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("saw_mstart", dut.mstart, 1);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("abort_P", P, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done, 0);

    run_op("after_rst", 2, 10, 1000, cy_a);
    chk("after_rst_const", P, 24);
    // Back-to-back from DONE; start_op checks done drops next cycle.
    run_op("b2b", 7, 2, 10, cy_a);
    chk("b2b_const", P, 9);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
